// File: rtl/ecc_gf_pkg.sv
//------------------------------------------------------------------------------
// Module   : ecc_gf_pkg
// Purpose  : Shared field definitions for the ECC arithmetic core.
//            Base field GF(2^8) mod x^8+x^4+x^3+x+1, extension field
//            GF((2^8)^5) mod y^5+y^2+1. The field multiplier and the
//            inverter must agree on these constants.
// Contents : GF8_POLY, EXT_TAP, gf40_t, inverter state encoding,
//            Fermat exponent constants, gf8_mul().
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ecc_gf_pkg;

  // Low byte of 0x11B; the x^8 term is implied by the shift-out bit.
  localparam logic [7:0] GF8_POLY = 8'h1B;

  // y^5 folds onto y^EXT_TAP and y^0 (y^5 = y^2 + 1).
  localparam int EXT_TAP = 2;

  // Element of GF((2^8)^5); index k holds the y^k coefficient.
  typedef logic [4:0][7:0] gf40_t;

  localparam gf40_t GF40_ONE = 40'h00_0000_0001;

  // Exponent 2^40-2: A^(2^40-2) = A^-1 for nonzero A, and 0 for A = 0.
  localparam logic [39:0] FERMAT_EXP = 40'hFF_FFFF_FFFE;
  localparam logic [5:0]  EXP_MSB    = 6'd39;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SQR  = 2'd1,
    ST_MUL  = 2'd2,
    ST_FIN  = 2'd3
  } inv_state_e;

  // Shift-and-xor multiply in GF(2^8), reducing by 0x11B on every shift.
  function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF8_POLY : 8'h00);
    end
    return acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ecc_field_inverter_gf40_mul_comb.sv
//------------------------------------------------------------------------------
// Module   : gf40_mul_comb
// Purpose  : Purely combinational multiply in GF((2^8)^5).
//            Forms the nine schoolbook partial coefficients y^0..y^8, then
//            folds y^8..y^5 back using y^5 = y^2 + 1.
// Ports    : i_a, i_b  operands (gf40_t)
//            o_p       product  (gf40_t)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gf40_mul_comb
  import ecc_gf_pkg::*;
(
  input  gf40_t i_a,
  input  gf40_t i_b,
  output gf40_t o_p
);

  logic [8:0][7:0] w_part;

  always_comb begin
    w_part = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        w_part[i+j] = w_part[i+j] ^ gf8_mul(i_a[i], i_b[j]);
      end
    end
    // Fold from the top down so the y^8 contribution landing on y^5 is
    // itself folded when k reaches 5.
    for (int k = 8; k >= 5; k--) begin
      w_part[k-5]         = w_part[k-5] ^ w_part[k];
      w_part[k-5+EXT_TAP] = w_part[k-5+EXT_TAP] ^ w_part[k];
    end
    o_p = w_part[4:0];
  end

endmodule

`default_nettype wire

// File: rtl/ecc_field_inverter.sv
//------------------------------------------------------------------------------
// Module   : ecc_field_inverter
// Purpose  : Sequential inverter in GF((2^8)^5) by Fermat exponentiation,
//            C = A^(2^40-2), square-and-multiply MSB first over one shared
//            combinational multiplier. 40 SQR + 39 MUL + 1 FIN cycles.
// Ports    : clk            rising-edge clock
//            reset          synchronous active-high reset
//            start          request, sampled only in IDLE
//            a0..a4         operand coefficients (a0 = y^0)
//            c0..c4         registered result, held until next start/reset
//            busy           registered, high after edges 1..79 of a run
//            done           one-cycle pulse, c0..c4 valid with it
//            zero           operand was 0; set with done, cleared on start
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ecc_field_inverter
  import ecc_gf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] a0,
  input  logic [7:0] a1,
  input  logic [7:0] a2,
  input  logic [7:0] a3,
  input  logic [7:0] a4,
  output logic [7:0] c0,
  output logic [7:0] c1,
  output logic [7:0] c2,
  output logic [7:0] c3,
  output logic [7:0] c4,
  output logic       busy,
  output logic       done,
  output logic       zero
);

  inv_state_e r_state;
  inv_state_e w_state_nxt;
  gf40_t      r_a;
  gf40_t      r_acc;
  gf40_t      w_acc_nxt;
  gf40_t      r_c;
  logic [5:0] r_idx;
  logic [5:0] w_idx_nxt;
  logic       r_busy;
  logic       r_done;
  logic       r_zero;
  logic       w_accept;

  gf40_t      w_mul_b;
  gf40_t      w_prod;

  assign w_accept = (r_state == ST_IDLE) && start;

  // Shared multiplier: (R,R) while squaring, (R,A) while multiplying.
  assign w_mul_b = (r_state == ST_MUL) ? r_a : r_acc;

  gf40_mul_comb u_mul (
    .i_a (r_acc),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SQR;
          w_acc_nxt   = GF40_ONE;
          w_idx_nxt   = EXP_MSB;
        end
      end
      ST_SQR: begin
        w_acc_nxt = w_prod;
        if (FERMAT_EXP[r_idx]) begin
          w_state_nxt = ST_MUL;
        end else if (r_idx == 6'd0) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_idx_nxt = r_idx - 6'd1;
        end
      end
      ST_MUL: begin
        w_acc_nxt = w_prod;
        if (r_idx == 6'd0) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_idx_nxt   = r_idx - 6'd1;
          w_state_nxt = ST_SQR;
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_acc   <= '0;
      r_idx   <= 6'd0;
      r_c     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_idx   <= w_idx_nxt;
      // busy lags the state by one edge so it spans edges 1..79 of a run.
      r_busy  <= (r_state == ST_SQR) || (r_state == ST_MUL);
      r_done  <= (r_state == ST_FIN);
      if (w_accept) begin
        r_a    <= {a4, a3, a2, a1, a0};
        r_zero <= 1'b0;
      end
      if (r_state == ST_FIN) begin
        r_c    <= r_acc;
        r_zero <= (r_a == '0);
      end
    end
  end

  assign c0   = r_c[0];
  assign c1   = r_c[1];
  assign c2   = r_c[2];
  assign c3   = r_c[3];
  assign c4   = r_c[4];
  assign busy = r_busy;
  assign done = r_done;
  assign zero = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_ecc_field_inverter.sv
//------------------------------------------------------------------------------
// Module   : tb_ecc_field_inverter
// Purpose  : Self-checking bench for ecc_field_inverter: directed vectors,
//            busy/reset handling and back-to-back random inversions.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ecc_field_inverter;

  localparam int N_RANDOM = 1000;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a0, a1, a2, a3, a4;
  logic [7:0] c0, c1, c2, c3, c4;
  logic       busy;
  logic       done;
  logic       zero;
  logic [39:0] c_all;

  int n_checks;
  int n_errors;
  int cyc;

  ecc_field_inverter dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a0    (a0),
    .a1    (a1),
    .a2    (a2),
    .a3    (a3),
    .a4    (a4),
    .c0    (c0),
    .c1    (c1),
    .c2    (c2),
    .c3    (c3),
    .c4    (c4),
    .busy  (busy),
    .done  (done),
    .zero  (zero)
  );

  assign c_all = {c4, c3, c2, c1, c0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%010h expected 0x%010h", tag, obs, exp);
    end
  endtask

  // Reference: full carry-less product, then reduce mod 0x11B.
  function automatic logic [7:0] m_gf8(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    logic [14:0] poly;
    p    = '0;
    poly = 15'h011B;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({7'b0, a} << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (poly << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [39:0] m_gf40(input logic [39:0] a, input logic [39:0] b);
    logic [7:0] t [9];
    for (int k = 0; k < 9; k++) t[k] = 8'h00;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        t[i+j] = t[i+j] ^ m_gf8(a[8*i +: 8], b[8*j +: 8]);
    for (int k = 8; k >= 5; k--) begin
      t[k-5] = t[k-5] ^ t[k];
      t[k-3] = t[k-3] ^ t[k];
    end
    return {t[4], t[3], t[2], t[1], t[0]};
  endfunction

  task automatic set_operand(input logic [39:0] a);
    {a4, a3, a2, a1, a0} = a;
  endtask

  // Start one inversion and observe 120 edges; inject_at > 0 pulses a
  // second start (different operand) after that edge while the core is busy.
  task automatic run_op(input logic [39:0] a, input int inject_at,
                        output logic [39:0] c, output int lat, output int ndone,
                        output logic z, output logic b0, output logic b1,
                        output logic b79, output logic bd);
    set_operand(a);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    b0 = busy; b1 = 1'b0; b79 = 1'b0; bd = 1'b1;
    c = '0; lat = 0; ndone = 0; z = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      @(posedge clk); #1;
      if (k == inject_at) begin
        set_operand(~a);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (k == 1)  b1  = busy;
      if (k == 79) b79 = busy;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          lat = k; c = c_all; z = zero; bd = busy;
        end
      end
    end
  endtask

  logic [39:0] vec_a   [4];
  logic [39:0] vec_c   [4];
  logic        vec_z   [4];
  int          vec_inj [4];

  initial begin
    logic [39:0] c_got;
    logic [39:0] ra;
    logic [39:0] prev_a;
    int lat, ndone, t_last, extra;
    logic z, b0, b1, b79, bd, seen;

    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    start = 1'b0;
    set_operand(40'h0);

    vec_a[0] = 40'h00_0000_0001; vec_c[0] = 40'h00_0000_0001; vec_z[0] = 1'b0; vec_inj[0] = 0;
    vec_a[1] = 40'h00_0000_0000; vec_c[1] = 40'h00_0000_0000; vec_z[1] = 1'b1; vec_inj[1] = 0;
    vec_a[2] = 40'h00_0000_0100; vec_c[2] = 40'h01_0000_0100; vec_z[2] = 1'b0; vec_inj[2] = 0;
    vec_a[3] = 40'h00_0000_0002; vec_c[3] = 40'h00_0000_008D; vec_z[3] = 1'b0; vec_inj[3] = 30;

    repeat (3) @(posedge clk);
    #1;
    check("rst_c",    c_all, 40'h0);
    check("rst_busy", {39'b0, busy}, 40'h0);
    check("rst_done", {39'b0, done}, 40'h0);
    check("rst_zero", {39'b0, zero}, 40'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors: 1, 0, y, 0x02 (the last with a start injected at 30).
    for (int v = 0; v < 4; v++) begin
      run_op(vec_a[v], vec_inj[v], c_got, lat, ndone, z, b0, b1, b79, bd);
      check($sformatf("vec%0d_c", v),     c_got, vec_c[v]);
      check($sformatf("vec%0d_zero", v),  {39'b0, z}, {39'b0, vec_z[v]});
      check($sformatf("vec%0d_lat", v),   40'(lat), 40'd80);
      check($sformatf("vec%0d_ndone", v), 40'(ndone), 40'd1);
      if (v == 0) begin
        check("busy_edge0", {39'b0, b0},  40'h0);
        check("busy_edge1", {39'b0, b1},  40'h1);
        check("busy_edge79",{39'b0, b79}, 40'h1);
        check("busy_done",  {39'b0, bd},  40'h0);
      end
    end
    check("hold_c", c_all, 40'h00_0000_008D);

    // Reset in the middle of a run.
    set_operand(40'h00_0001_0000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 40; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {39'b0, busy}, 40'h0);
    check("abort_done", {39'b0, done}, 40'h0);
    check("abort_c",    c_all, 40'h0);
    check("abort_zero", {39'b0, zero}, 40'h0);
    reset = 1'b0;
    extra = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("abort_nodone", 40'(extra), 40'd0);

    // Fresh start after the abort completes normally.
    run_op(40'h00_0000_0100, 0, c_got, lat, ndone, z, b0, b1, b79, bd);
    check("fresh_c",   c_got, 40'h01_0000_0100);
    check("fresh_lat", 40'(lat), 40'd80);

    // Back-to-back random nonzero operands, next start in each done cycle.
    ra = {$urandom_range(255), $urandom()};
    if (ra == 40'h0) ra = 40'h1;
    set_operand(ra);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t_last = cyc;
    prev_a = ra;
    for (int n = 0; n < N_RANDOM; n++) begin
      seen = 1'b0;
      for (int w = 0; w < 100; w++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        check("rnd_timeout", 40'h0, 40'h1);
        break;
      end
      check("rnd_inv",  m_gf40(prev_a, c_all), 40'h1);
      check("rnd_zero", {39'b0, zero}, 40'h0);
      check("rnd_gap",  40'(cyc - t_last), (n == 0) ? 40'd80 : 40'd81);
      t_last = cyc;
      if (n < N_RANDOM - 1) begin
        ra = {$urandom_range(255), $urandom()};
        if (ra == 40'h0) ra = 40'h1;
        set_operand(ra);
        prev_a = ra;
        start = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
